// File: rtl/vm_pkg.sv
// vm_pkg: shared types and sizes for the vector mask writeback path.
package vm_pkg;
    localparam int VM_AW = 3;
    localparam int VM_DW = 128;
    localparam int VM_NREGS = 8;
    localparam int VM_WB_DEPTH = 8;
    typedef logic [VM_AW-1:0] vm_addr_t;
    typedef logic [VM_DW-1:0] vm_data_t;
    typedef struct packed {
        vm_addr_t wa;
        vm_data_t d;
    } vm_wb_t;
endpackage

// File: rtl/vm_wb_fifo2.sv
// vm_wb_fifo2: in-order FIFO of writeback entries, up to two pushes and two pops per cycle.
module vm_wb_fifo2
    import vm_pkg::*;
#(
    parameter int DEPTH = VM_WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic                       i_push0,
    input  logic                       i_push1,
    input  vm_wb_t                     i_d0,
    input  vm_wb_t                     i_d1,
    input  logic [1:0]                 i_pop,
    output vm_wb_t                     o_head0,
    output vm_wb_t                     o_head1,
    output logic [$clog2(DEPTH):0]     o_cnt,
    output logic [DEPTH-1:0]           o_slot_v,
    output vm_addr_t [DEPTH-1:0]       o_slot_wa
);
    localparam int PW = $clog2(DEPTH);
    vm_wb_t r_mem [DEPTH];
    logic [PW:0] r_wp, r_rp;
    logic [PW:0] r_cnt;
    logic [1:0] w_npush;
    logic [PW-1:0] w_wp1, w_rp1;
    assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
    assign w_wp1 = r_wp[PW-1:0] + PW'(1);
    assign w_rp1 = r_rp[PW-1:0] + PW'(1);
    assign o_head0 = r_mem[r_rp[PW-1:0]];
    assign o_head1 = r_mem[w_rp1];
    assign o_cnt = r_cnt;
    // A lone lane-1 push takes the next single slot, same as a lone lane-0 push.
    always_ff @(posedge clk) begin
        if (i_push0 | i_push1) r_mem[r_wp[PW-1:0]] <= i_push0 ? i_d0 : i_d1;
        if (i_push0 & i_push1) r_mem[w_wp1] <= i_d1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            r_wp <= r_wp + (PW+1)'(w_npush);
            r_rp <= r_rp + (PW+1)'(i_pop);
            r_cnt <= r_cnt + (PW+1)'(w_npush) - (PW+1)'(i_pop);
        end
    end
    always_comb begin
        o_slot_v = '0;
        o_slot_wa = '0;
        for (int s = 0; s < DEPTH; s++) begin
            o_slot_v[s] = {1'b0, PW'(s) - r_rp[PW-1:0]} < r_cnt;
            o_slot_wa[s] = r_mem[s].wa;
        end
    end
endmodule

// File: rtl/vm_wb_queue.sv
// vm_wb_queue: dual-lane writeback buffer feeding the mask register file's two write ports,
// with a pending-write scoreboard over queued and staged entries.
module vm_wb_queue
    import vm_pkg::*;
#(
    parameter int DEPTH = VM_WB_DEPTH,
    parameter int AW = VM_AW,
    parameter int DW = VM_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in0_v,
    input  logic [AW-1:0]          in0_wa,
    input  logic [DW-1:0]          in0_d,
    output logic                   in0_rdy,
    input  logic                   in1_v,
    input  logic [AW-1:0]          in1_wa,
    input  logic [DW-1:0]          in1_d,
    output logic                   in1_rdy,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   wr0,
    output logic                   wr1,
    output logic [AW-1:0]          wa0,
    output logic [AW-1:0]          wa1,
    output logic [DW-1:0]          i0,
    output logic [DW-1:0]          i1,
    output logic [2**AW-1:0]       pend,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic r_rdy, r_wr0, r_wr1;
    logic [AW-1:0] r_wa0, r_wa1;
    logic [DW-1:0] r_i0, r_i1;
    logic w_enq0, w_enq1, w_two, w_one;
    logic [1:0] w_pop;
    logic [CW-1:0] w_cnt_nxt;
    vm_wb_t w_d0, w_d1, w_head0, w_head1;
    logic [DEPTH-1:0] w_slot_v;
    vm_addr_t [DEPTH-1:0] w_slot_wa;
    assign w_d0 = {in0_wa, in0_d};
    assign w_d1 = {in1_wa, in1_d};
    assign w_enq0 = in0_v & r_rdy & ~flush;
    assign w_enq1 = in1_v & r_rdy & ~flush;
    assign w_two = cnt >= CW'(2);
    assign w_one = cnt != '0;
    assign w_pop = (hold | flush) ? 2'd0 : w_two ? 2'd2 : {1'b0, w_one};
    assign w_cnt_nxt = flush ? '0 : cnt + CW'(w_enq0) + CW'(w_enq1) - CW'(w_pop);
    assign in0_rdy = r_rdy;
    assign in1_rdy = r_rdy;
    assign {wr0, wr1, wa0, wa1, i0, i1} = {r_wr0, r_wr1, r_wa0, r_wa1, r_i0, r_i1};
    vm_wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (flush),
        .i_push0  (w_enq0),
        .i_push1  (w_enq1),
        .i_d0     (w_d0),
        .i_d1     (w_d1),
        .i_pop    (w_pop),
        .o_head0  (w_head0),
        .o_head1  (w_head1),
        .o_cnt    (cnt),
        .o_slot_v (w_slot_v),
        .o_slot_wa(w_slot_wa)
    );
    // Ready is registered from next occupancy so it never depends on this cycle's valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
            {r_wr0, r_wr1, r_wa0, r_wa1, r_i0, r_i1} <= '0;
        end else begin
            r_rdy <= w_cnt_nxt <= CW'(DEPTH-2);
            r_wr0 <= ~(hold | flush) & w_one;
            r_wr1 <= ~(hold | flush) & w_two;
            if (!(hold | flush) && w_one) begin
                r_wa0 <= w_head0.wa;
                r_i0 <= w_head0.d;
            end
            if (!(hold | flush) && w_two) begin
                r_wa1 <= w_head1.wa;
                r_i1 <= w_head1.d;
            end
        end
    end
    always_comb begin
        pend = '0;
        for (int s = 0; s < DEPTH; s++)
            if (w_slot_v[s]) pend[w_slot_wa[s]] = 1'b1;
        if (r_wr0) pend[r_wa0] = 1'b1;
        if (r_wr1) pend[r_wa1] = 1'b1;
    end
endmodule

// File: tb/tb_vm_wb_queue.sv
// tb_vm_wb_queue: directed and random traffic against a queue-based reference model.
module tb_vm_wb_queue;
    import vm_pkg::*;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in0_v = 0, in1_v = 0, hold = 0, flush = 0;
    logic [2:0] in0_wa = 0, in1_wa = 0;
    logic [127:0] in0_d = 0, in1_d = 0;
    logic in0_rdy, in1_rdy, wr0, wr1;
    logic [2:0] wa0, wa1;
    logic [127:0] i0, i1;
    logic [7:0] pend;
    logic [3:0] cnt;
    vm_wb_t q[$];
    logic m_wr0, m_wr1, m_rdy;
    logic [2:0] m_wa0, m_wa1;
    logic [127:0] m_i0, m_i1;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    vm_wb_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in0_v(in0_v), .in0_wa(in0_wa), .in0_d(in0_d), .in0_rdy(in0_rdy),
        .in1_v(in1_v), .in1_wa(in1_wa), .in1_d(in1_d), .in1_rdy(in1_rdy),
        .hold(hold), .flush(flush),
        .wr0(wr0), .wr1(wr1), .wa0(wa0), .wa1(wa1), .i0(i0), .i1(i1),
        .pend(pend), .cnt(cnt)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] p;
        p = '0;
        foreach (q[j]) p[q[j].wa] = 1'b1;
        if (m_wr0) p[m_wa0] = 1'b1;
        if (m_wr1) p[m_wa1] = 1'b1;
        chk("cnt", cnt, q.size());
        chk("rdy0", in0_rdy, m_rdy);
        chk("rdy1", in1_rdy, m_rdy);
        chk("wr0", wr0, m_wr0);
        chk("wr1", wr1, m_wr1);
        chk("wa0", wa0, m_wa0);
        chk("wa1", wa1, m_wa1);
        chk("i0", i0, m_i0);
        chk("i1", i1, m_i1);
        chk("pend", pend, p);
    endtask

    task automatic step(input logic v0, input logic [2:0] a0, input logic [127:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [127:0] d1,
                        input logic h, input logic f);
        vm_wb_t e;
        logic e0, e1;
        {in0_v, in0_wa, in0_d, in1_v, in1_wa, in1_d, hold, flush} = {v0, a0, d0, v1, a1, d1, h, f};
        e0 = v0 && m_rdy && !f;
        e1 = v1 && m_rdy && !f;
        if (f) q.delete();
        m_wr0 = !f && !h && q.size() > 0;
        m_wr1 = !f && !h && q.size() > 1;
        if (m_wr0) begin e = q.pop_front(); m_wa0 = e.wa; m_i0 = e.d; end
        if (m_wr1) begin e = q.pop_front(); m_wa1 = e.wa; m_i1 = e.d; end
        if (e0) q.push_back('{wa: a0, d: d0});
        if (e1) q.push_back('{wa: a1, d: d1});
        m_rdy = q.size() <= DEPTH - 2;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic h);
        step(0, 0, 0, 0, 0, 0, h, 0);
    endtask

    task automatic enq1(input logic h);
        step(1, 3'($urandom), rnd128(), 0, 0, 0, h, 0);
    endtask

    task automatic enq2(input logic h);
        step(1, 3'($urandom), rnd128(), 1, 3'($urandom), rnd128(), h, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {in0_v, in1_v, hold, flush} = '0;
        q.delete();
        {m_wr0, m_wr1, m_wa0, m_wa1, m_i0, m_i1, m_rdy} = '0;
        #2;
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #6;
        do_reset();
        idle(0);
        // single write to register 3
        step(1, 3, {16{8'hA5}}, 0, 0, 0, 0, 0);
        idle(0);
        idle(0);
        idle(0);
        // same-address pair on both ports in one cycle
        step(1, 2, 128'd1, 1, 2, 128'd2, 0, 0);
        idle(0);
        idle(0);
        // fill under hold, try overfill, then dual drains across the wrap
        for (int k = 0; k < 6; k++) enq1(1);
        enq2(1);
        enq1(1);
        for (int k = 0; k < 5; k++) idle(0);
        // flush racing an enqueue
        enq2(1);
        enq2(1);
        step(1, 5, rnd128(), 0, 0, 0, 0, 1);
        idle(0);
        idle(0);
        // odd count drain
        enq2(1);
        enq1(1);
        idle(0);
        idle(0);
        idle(0);
        // flush together with hold
        enq2(1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle(0);
        // random traffic
        for (int k = 0; k < 400; k++)
            step($urandom % 2 == 0, 3'($urandom), rnd128(), $urandom % 2 == 0, 3'($urandom), rnd128(),
                 $urandom % 4 == 0, $urandom % 25 == 0);
        // reset mid-traffic with five entries queued
        step(0, 0, 0, 0, 0, 0, 0, 1);
        enq2(1);
        enq2(1);
        enq1(1);
        chk("cnt_before_reset", cnt, 5);
        do_reset();
        idle(0);
        enq2(0);
        idle(0);
        idle(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
